// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and the future UART transmitter:
//   - rx_state_e    : receiver FSM state encoding (2 bits)
//   - OVERSAMPLE    : baud ticks per bit period
//   - MID_TICK      : tick index at the middle of the start bit
//   - LAST_BIT_TICK : tick index that closes one full bit period
//   - DEF_DBIT      : default data bits per frame
//   - DEF_SB_TICK   : default ticks spent in the stop bit(s)
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int         OVERSAMPLE    = 16;
    localparam logic [4:0] MID_TICK      = 5'd7;
    localparam logic [4:0] LAST_BIT_TICK = 5'(OVERSAMPLE - 1);

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so that a reset never looks like a start-bit edge to the receiver.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   d     : asynchronous input (serial line)
//   q     : synchronized output, 2 clk behind d
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Synchronizer chain, idles at the line's mark level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver driven by a 16x oversampling tick. Detects the start bit,
// samples DBIT data bits LSB-first at mid-bit, checks the stop bit and
// presents the received word with a one-cycle done pulse and a framing
// error flag.
// Parameters:
//   DBIT    : data bits per frame (5..8)
//   SB_TICK : ticks spent in the stop bit (16 = 1, 24 = 1.5, 32 = 2 stop bits)
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   rx           : serial line, asynchronous, idles high
//   s_tick       : one-cycle oversampling strobe, 16 per bit period
//   dout         : last received data word
//   rx_done_tick : one-cycle pulse when a frame completes
//   frame_err    : stop-bit error of the last completed frame
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);

    logic            rx_s;

    rx_state_e       state_r;
    rx_state_e       state_nx_s;
    logic [4:0]      s_r;
    logic [4:0]      s_nx_s;
    logic [2:0]      n_r;
    logic [2:0]      n_nx_s;
    logic [DBIT-1:0] b_r;
    logic [DBIT-1:0] b_nx_s;
    logic [DBIT-1:0] dout_r;
    logic [DBIT-1:0] dout_nx_s;
    logic            done_r;
    logic            done_nx_s;
    logic            ferr_r;
    logic            ferr_nx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            s_r     <= 5'd0;
            n_r     <= 3'd0;
            b_r     <= '0;
            dout_r  <= '0;
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            s_r     <= s_nx_s;
            n_r     <= n_nx_s;
            b_r     <= b_nx_s;
            dout_r  <= dout_nx_s;
            done_r  <= done_nx_s;
            ferr_r  <= ferr_nx_s;
        end
    end

    // Next-state, counter and output computation; everything holds by default
    // so cycles without s_tick freeze the receiver in place.
    always_comb begin
        state_nx_s = state_r;
        s_nx_s     = s_r;
        n_nx_s     = n_r;
        b_nx_s     = b_r;
        dout_nx_s  = dout_r;
        ferr_nx_s  = ferr_r;
        done_nx_s  = 1'b0;

        case (state_r)
            IDLE: begin
                // Edge detection does not wait for a tick; a tick in this
                // same cycle is deliberately not counted.
                if (rx_s == 1'b0) begin
                    state_nx_s = START;
                    s_nx_s     = 5'd0;
                end else begin
                    state_nx_s = IDLE;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_r == MID_TICK) begin
                        // Line must still be low mid start bit, otherwise it
                        // was a glitch and the outputs are left untouched.
                        if (rx_s == 1'b0) begin
                            state_nx_s = DATA;
                            s_nx_s     = 5'd0;
                            n_nx_s     = 3'd0;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        s_nx_s = s_r + 5'd1;
                    end
                end else begin
                    s_nx_s = s_r;
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_r == LAST_BIT_TICK) begin
                        s_nx_s = 5'd0;
                        b_nx_s = {rx_s, b_r[DBIT-1:1]};
                        if (n_r == N_LAST) begin
                            state_nx_s = STOP;
                        end else begin
                            n_nx_s = n_r + 3'd1;
                        end
                    end else begin
                        s_nx_s = s_r + 5'd1;
                    end
                end else begin
                    s_nx_s = s_r;
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_r == STOP_LAST) begin
                        // A bad stop bit still completes the frame.
                        state_nx_s = IDLE;
                        dout_nx_s  = b_r;
                        ferr_nx_s  = ~rx_s;
                        done_nx_s  = 1'b1;
                    end else begin
                        s_nx_s = s_r + 5'd1;
                    end
                end else begin
                    s_nx_s = s_r;
                end
            end

            default: begin
                state_nx_s = IDLE;
                s_nx_s     = 5'd0;
                n_nx_s     = 3'd0;
            end
        endcase
    end

    assign dout         = dout_r;
    assign rx_done_tick = done_r;
    assign frame_err    = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Directed and randomized frames driven at 64 clk per bit, with a tick every
// 4 clk. Two receivers share the line: a 1-stop-bit build and a 2-stop-bit
// build. Expected words and error flags come from the frame contents
// themselves (dout = sent byte, frame_err = stop bit was low).
// ----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       s_tick;
    logic [1:0] tdiv   = 2'd0;
    int         cyc    = 0;

    logic [7:0] dout16;
    logic       done16;
    logic       ferr16;
    logic [7:0] dout32;
    logic       done32;
    logic       ferr32;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_dout16[$];
    logic       q_fe16[$];
    int         q_cyc16[$];
    logic [7:0] q_dout32[$];
    logic       q_fe32[$];
    int         q_cyc32[$];
    int         seen16 = 0;
    int         seen32 = 0;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout16),
        .rx_done_tick (done16),
        .frame_err    (ferr16)
    );

    uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout32),
        .rx_done_tick (done32),
        .frame_err    (ferr32)
    );

    always #5 clk = ~clk;

    // Baud generator with dvsr=3: one tick every 4 clk.
    always @(posedge clk) begin
        tdiv <= tdiv + 2'd1;
        cyc  <= cyc + 1;
    end
    assign s_tick = (tdiv == 2'd3);

    // Record every cycle the done strobe is high, away from the active edge.
    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            q_dout16.push_back(dout16);
            q_fe16.push_back(ferr16);
            q_cyc16.push_back(cyc);
        end
        if (done32 === 1'b1) begin
            q_dout32.push_back(dout32);
            q_fe32.push_back(ferr32);
            q_cyc32.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk) rx = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input int nstop, output int c0);
        @(negedge clk) rx = 1'b0;
        c0 = cyc;
        repeat (63) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 64);
        if (stop_ok) begin
            for (int k = 0; k < nstop; k++) drive_bit(1'b1, 64);
        end else begin
            // Low across the stop-bit sample point, high again before the
            // resulting false start is checked at its midpoint.
            drive_bit(1'b0, 48);
            drive_bit(1'b1, 16);
        end
    endtask

    // One pulse expected since the last check, carrying d / fe, near the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] d,
                               input logic fe, input int c0);
        chk({tag, " pulses"}, q_dout16.size() - seen16, 1);
        if (q_dout16.size() > seen16) begin
            chk({tag, " dout"}, q_dout16[seen16], d);
            chk({tag, " ferr"}, q_fe16[seen16], fe);
            chk({tag, " window"},
                (q_cyc16[seen16] >= c0 + 544 && q_cyc16[seen16] <= c0 + 704), 1);
            chk({tag, " hold"}, dout16, d);
        end
        seen16 = q_dout16.size();
    endtask

    initial begin
        int         c0;
        int         cb[3];
        logic [7:0] bb[3];
        logic [7:0] d;
        logic       ok;
        logic [7:0] f0;

        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst dout", dout16, 8'h00);
        chk("rst done", done16, 1'b0);
        chk("rst ferr", ferr16, 1'b0);
        chk("rst dout32", dout32, 8'h00);
        drive_bit(1'b1, 40);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1, 1, c0);
        drive_bit(1'b1, 30);
        check_frame("a5", 8'hA5, 1'b0, c0);

        // Start glitch: 16 clk low then idle
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 200);
        chk("glitch pulses", q_dout16.size() - seen16, 0);
        chk("glitch dout", dout16, 8'hA5);
        chk("glitch ferr", ferr16, 1'b0);
        seen16 = q_dout16.size();

        // Bad stop bit, then a good frame
        send_frame(8'h3C, 1'b0, 1, c0);
        drive_bit(1'b1, 40);
        check_frame("3c bad", 8'h3C, 1'b1, c0);
        send_frame(8'h81, 1'b1, 1, c0);
        drive_bit(1'b1, 30);
        check_frame("81", 8'h81, 1'b0, c0);

        // Back-to-back frames with no idle gap
        bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_frame(bb[i], 1'b1, 1, cb[i]);
        drive_bit(1'b1, 30);
        chk("b2b pulses", q_dout16.size() - seen16, 3);
        if (q_dout16.size() >= seen16 + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("b2b dout", q_dout16[seen16 + i], bb[i]);
                chk("b2b ferr", q_fe16[seen16 + i], 1'b0);
                chk("b2b window", (q_cyc16[seen16 + i] >= cb[i] + 544 &&
                                   q_cyc16[seen16 + i] <= cb[i] + 704), 1);
            end
        end
        seen16 = q_dout16.size();

        // Randomized frames against the frame-level reference
        for (int r = 0; r < 6; r++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok, 1, c0);
            drive_bit(1'b1, $urandom_range(20, 100));
            check_frame("rand", d, ~ok, c0);
        end

        // Make the outputs non-zero before the reset test
        send_frame(8'hC3, 1'b0, 1, c0);
        drive_bit(1'b1, 40);
        check_frame("pre rst", 8'hC3, 1'b1, c0);

        // Reset during bit 4 of 0xF0
        f0 = 8'hF0;
        drive_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) drive_bit(f0[i], 64);
        @(negedge clk) rx = f0[4];
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (42) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(f0[i], 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b1, 100);
        chk("abort pulses", q_dout16.size() - seen16, 0);
        chk("abort dout", dout16, 8'h00);
        chk("abort ferr", ferr16, 1'b0);
        chk("abort done", done16, 1'b0);
        seen16 = q_dout16.size();
        send_frame(8'h5A, 1'b1, 1, c0);
        drive_bit(1'b1, 30);
        check_frame("5a", 8'h5A, 1'b0, c0);

        // Two-stop-bit build versus one-stop-bit build on the same frame
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        drive_bit(1'b1, 100);
        seen16 = q_dout16.size();
        seen32 = q_dout32.size();
        send_frame(8'h96, 1'b1, 2, c0);
        drive_bit(1'b1, 64);
        chk("sb32 pulses", q_dout32.size() - seen32, 1);
        chk("sb16 pulses", q_dout16.size() - seen16, 1);
        if (q_dout32.size() > seen32 && q_dout16.size() > seen16) begin
            chk("sb32 dout", q_dout32[seen32], 8'h96);
            chk("sb32 ferr", q_fe32[seen32], 1'b0);
            chk("sb16 dout", q_dout16[seen16], 8'h96);
            chk("sb32 delay", q_cyc32[seen32] - q_cyc16[seen16], 64);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
